f_fetch_unit: RTL and testbench

F-stage fetch engine: holds F_PC, fetches instructions from a variable-latency instruction memory over a req/gnt/rvalid handshake, and presents one instruction at a time to the D stage. It consumes the NPC value produced by the D-stage next-PC logic and loads it into F_PC when D accepts the current instruction. It also flags instruction-address errors (AdEL) without issuing a memory request.

---
 rtl/f_fetch_unit.sv | 98 +++++++++
 tb/tb_f_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_unit.sv
// F-stage fetch engine: owns F_PC, fetches one instruction at a time over a
// req/gnt/rvalid instruction-memory handshake and presents it to D.
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        D_stall,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_adel,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        adel_q;
  logic        pcLegal;

  // Illegal PCs never reach memory; they are turned into a nop carrying AdEL.
  assign pcLegal = (pc_q[1:0] == 2'b00) && (pc_q >= IM_BASE) && (pc_q <= IM_LIMIT);

  assign imem_req  = (state_q == S_REQ) && pcLegal;
  assign imem_addr = pc_q;
  assign F_PC      = pc_q;
  assign F_instr   = instr_q;
  assign F_valid   = valid_q;
  assign F_adel    = adel_q;

  // Handshake sequencing; gnt outside REQ and rvalid outside WAIT are ignored,
  // which also drops responses to requests abandoned by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (!pcLegal) begin
            instr_q <= 32'h0000_0000;
            adel_q  <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else if (imem_gnt) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            adel_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!D_stall) begin
            pc_q    <= NPC;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

  // An ungranted request must stay up with the same address.
  reqStableAssert: assert property (@(posedge clk) disable iff (reset)
    (imem_req && !imem_gnt) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: table vectors, hand-written reset and
// stall sequences, then randomized traffic against a transaction-level model.
module tb_f_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6ffc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC;
  logic        D_stall;
  logic [31:0] F_PC;
  logic [31:0] F_instr;
  logic        F_valid;
  logic        F_adel;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  always #5 clk = ~clk;

  f_fetch_unit #(
    .RESET_PC(RESET_PC),
    .IM_BASE (IM_BASE),
    .IM_LIMIT(IM_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .NPC        (NPC),
    .D_stall    (D_stall),
    .F_PC       (F_PC),
    .F_instr    (F_instr),
    .F_valid    (F_valid),
    .F_adel     (F_adel),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata)
  );

  typedef struct {
    logic [31:0] npc;
    int          gntDly;
    int          rvDly;
    int          stall;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic        expAdel;
    int          expLat;
  } vec_t;

  int          totalChecks = 0;
  int          passedChecks = 0;

  bit          memManual;
  bit          strayEn;
  int          gntDelay;
  int          rvDelay;
  int          gntCnt;
  int          rvCnt;
  bit          respPending;
  logic [31:0] respAddr;

  bit          checkActive;
  logic [31:0] curExpPc;
  logic [31:0] lastExpInstr;

  vec_t        vecs[11];

  function automatic bit legalPc(input logic [31:0] pc);
    return (pc % 4 == 0) && (pc >= IM_BASE) && (pc <= IM_LIMIT);
  endfunction

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalChecks++;
    if (actual === expected) passedChecks++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
  endtask

  // Memory responder: gnt after gntDelay cycles of req, rvalid rvDelay cycles after gnt.
  task automatic memStep();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (respPending) begin
      if (rvCnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(respAddr);
        respPending = 1'b0;
      end else begin
        rvCnt--;
      end
    end else if (imem_req) begin
      if (gntCnt == gntDelay) begin
        imem_gnt    = 1'b1;
        respPending = 1'b1;
        respAddr    = imem_addr;
        rvCnt       = rvDelay;
        gntCnt      = 0;
      end else begin
        gntCnt++;
      end
    end else if (strayEn) begin
      imem_gnt    = ($urandom_range(0, 3) == 0);
      imem_rvalid = ($urandom_range(0, 3) == 0);
    end
  endtask

  // One clock: advance to the falling edge, drive memory, check invariants.
  task automatic tick();
    @(negedge clk);
    if (!memManual) memStep();
    if (checkActive && !reset) begin
      checkOutput("fpcTrack", F_PC, curExpPc);
      if (!legalPc(curExpPc)) checkOutput("noReqIllegal", {31'b0, imem_req}, 32'd0);
      if (imem_req) checkOutput("reqAddr", imem_addr, curExpPc);
    end
  endtask

  // Starting from a presented instruction: stall, accept npc, wait for the next one.
  task automatic applyStimulus(input logic [31:0] npc, input int g, input int r,
                               input int stallCycles, input logic [31:0] expPc,
                               input logic [31:0] expInstr, input logic expAdel,
                               input int expLat);
    int lat;
    for (int s = 0; s < stallCycles; s++) begin
      D_stall = 1'b1;
      NPC     = $urandom;
      tick();
      checkOutput("stallValid", {31'b0, F_valid}, 32'd1);
      checkOutput("stallInstr", F_instr, lastExpInstr);
    end
    gntDelay = g;
    rvDelay  = r;
    gntCnt   = 0;
    D_stall  = 1'b0;
    NPC      = npc;
    curExpPc = expPc;
    tick();
    lat = 1;
    checkOutput("acceptBubble", {31'b0, F_valid}, 32'd0);
    while (!F_valid && lat < 40) begin
      D_stall = $urandom_range(0, 1);
      NPC     = $urandom;
      tick();
      lat++;
    end
    D_stall = 1'b1;
    checkOutput("presentValid", {31'b0, F_valid}, 32'd1);
    checkOutput("presentPc", F_PC, expPc);
    checkOutput("presentInstr", F_instr, expInstr);
    checkOutput("presentAdel", {31'b0, F_adel}, {31'b0, expAdel});
    checkOutput("latency", 32'(lat), 32'(expLat));
    lastExpInstr = expInstr;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] npc;
    logic [31:0] pcA;
    int          g;
    int          r;
    int          lat;

    vecs[0]  = '{32'h0000_3004, 0, 0, 0, 32'h0000_3004, memWord(32'h0000_3004), 1'b0, 3};
    vecs[1]  = '{32'h0000_3008, 2, 0, 0, 32'h0000_3008, memWord(32'h0000_3008), 1'b0, 5};
    vecs[2]  = '{32'h0000_300c, 0, 0, 0, 32'h0000_300c, memWord(32'h0000_300c), 1'b0, 3};
    vecs[3]  = '{32'h0000_3010, 0, 0, 4, 32'h0000_3010, memWord(32'h0000_3010), 1'b0, 3};
    vecs[4]  = '{32'h0000_4000, 1, 1, 1, 32'h0000_4000, memWord(32'h0000_4000), 1'b0, 5};
    vecs[5]  = '{32'h0000_3002, 0, 0, 0, 32'h0000_3002, 32'h0000_0000,          1'b1, 2};
    vecs[6]  = '{32'h0000_7000, 0, 0, 0, 32'h0000_7000, 32'h0000_0000,          1'b1, 2};
    vecs[7]  = '{32'h0000_6ffc, 0, 2, 0, 32'h0000_6ffc, memWord(32'h0000_6ffc), 1'b0, 5};
    vecs[8]  = '{32'h0000_2ffc, 0, 0, 2, 32'h0000_2ffc, 32'h0000_0000,          1'b1, 2};
    vecs[9]  = '{32'hffff_fffc, 0, 0, 0, 32'hffff_fffc, 32'h0000_0000,          1'b1, 2};
    vecs[10] = '{32'h0000_3000, 0, 0, 0, 32'h0000_3000, memWord(32'h0000_3000), 1'b0, 3};

    reset       = 1'b1;
    D_stall     = 1'b1;
    NPC         = 32'h0;
    memManual   = 1'b1;
    strayEn     = 1'b0;
    checkActive = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    gntDelay = 0; rvDelay = 0; gntCnt = 0; rvCnt = 0;
    respPending = 1'b0; respAddr = 32'h0;
    curExpPc = RESET_PC; lastExpInstr = 32'h0;

    // Reset values, then one BOOT cycle and a first fetch answered with gnt/rvalid.
    repeat (3) @(negedge clk);
    checkOutput("rstPc", F_PC, 32'h0000_3000);
    checkOutput("rstInstr", F_instr, 32'h0);
    checkOutput("rstValid", {31'b0, F_valid}, 32'd0);
    checkOutput("rstAdel", {31'b0, F_adel}, 32'd0);
    checkOutput("rstReq", {31'b0, imem_req}, 32'd0);
    checkOutput("rstAddr", imem_addr, 32'h0000_3000);
    reset    = 1'b0;
    imem_gnt = 1'b1;
    #1 checkOutput("bootNoReq", {31'b0, imem_req}, 32'd0);
    tick();
    checkOutput("firstReq", {31'b0, imem_req}, 32'd1);
    checkOutput("firstAddr", imem_addr, 32'h0000_3000);
    tick();
    checkOutput("waitNoReq", {31'b0, imem_req}, 32'd0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3c01_1234;
    tick();
    imem_rvalid = 1'b0;
    checkOutput("firstValid", {31'b0, F_valid}, 32'd1);
    checkOutput("firstInstr", F_instr, 32'h3c01_1234);
    checkOutput("firstPc", F_PC, 32'h0000_3000);
    checkOutput("firstAdel", {31'b0, F_adel}, 32'd0);
    lastExpInstr = 32'h3c01_1234;
    curExpPc     = 32'h0000_3000;
    memManual    = 1'b0;
    checkActive  = 1'b1;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].npc, vecs[i].gntDly, vecs[i].rvDly, vecs[i].stall,
                    vecs[i].expPc, vecs[i].expInstr, vecs[i].expAdel, vecs[i].expLat);
    end

    // Reset in WAIT, stray rvalid during BOOT must be dropped.
    gntDelay = 0; rvDelay = 6; gntCnt = 0;
    D_stall  = 1'b0;
    NPC      = 32'h0000_3014;
    curExpPc = 32'h0000_3014;
    tick();
    D_stall = 1'b1;
    tick();
    checkOutput("inWaitNoReq", {31'b0, imem_req}, 32'd0);
    checkActive = 1'b0;
    memManual   = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    reset       = 1'b1;
    #1;
    checkOutput("midRstPc", F_PC, 32'h0000_3000);
    checkOutput("midRstValid", {31'b0, F_valid}, 32'd0);
    checkOutput("midRstInstr", F_instr, 32'h0);
    checkOutput("midRstReq", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    reset       = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hffff_ffff;
    tick();
    imem_rvalid = 1'b0;
    checkOutput("rstReqAgain", {31'b0, imem_req}, 32'd1);
    checkOutput("rstReqAddr", imem_addr, 32'h0000_3000);
    checkOutput("strayIgnValid", {31'b0, F_valid}, 32'd0);
    checkOutput("strayIgnInstr", F_instr, 32'h0);
    respPending = 1'b0; gntCnt = 0; gntDelay = 0; rvDelay = 0;
    curExpPc    = 32'h0000_3000;
    memManual   = 1'b0;
    checkActive = 1'b1;
    memStep();
    lat = 0;
    while (!F_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("refetchLat", 32'(lat), 32'd2);
    checkOutput("refetchInstr", F_instr, memWord(32'h0000_3000));
    checkOutput("refetchPc", F_PC, 32'h0000_3000);
    lastExpInstr = memWord(32'h0000_3000);

    // Randomized traffic against the transaction model.
    strayEn = 1'b1;
    for (int t = 0; t < 60; t++) begin
      pcA = curExpPc;
      case ($urandom_range(0, 9))
        6: npc = IM_BASE + 32'($urandom_range(0, 4095)) * 4;
        7: npc = $urandom;
        8: npc = pcA + 2;
        9: npc = ($urandom_range(0, 1) == 0) ? IM_LIMIT : IM_LIMIT + 4;
        default: npc = pcA + 4;
      endcase
      g = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      if (legalPc(npc))
        applyStimulus(npc, g, r, $urandom_range(0, 3), npc, memWord(npc), 1'b0, 3 + g + r);
      else
        applyStimulus(npc, g, r, $urandom_range(0, 3), npc, 32'h0, 1'b1, 2);
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
